// File: rtl/alu_pipe_pkg.sv
// Shared types and the half-word execute function for the elastic ALU pipeline.
package alu_pipe_pkg;

    localparam int HALF_W = 16;
    localparam int RES_W  = HALF_W + 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    // Operands are zero-extended by one bit so ADD keeps its carry and SUB wraps mod 2^RES_W.
    function automatic logic [RES_W-1:0] alu_exec(input logic [HALF_W-1:0] a,
                                                   input logic [HALF_W-1:0] b,
                                                   input op_e op);
        logic [RES_W-1:0] ax;
        logic [RES_W-1:0] bx;
        logic [RES_W-1:0] r;
        ax = {1'b0, a};
        bx = {1'b0, b};
        case (op)
            OP_ADD:  r = ax + bx;
            OP_SUB:  r = ax - bx;
            OP_AND:  r = ax & bx;
            default: r = ax ^ bx;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// Elastic register slice: one payload register with a valid bit and a
// combinational ready pass-through, so an empty slice always accepts.
module pipe_slice #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    // Load when empty or when the current content moves on this cycle.
    assign up_ready = !dn_valid || dn_ready;

    // Valid tracks the upstream handshake; flush drops the entry but leaves data alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else begin
            if (flush)
                dn_valid <= 1'b0;
            else if (up_ready)
                dn_valid <= up_valid;
            if (up_valid && up_ready)
                dn_data <= up_data;
        end
    end

endmodule

// File: rtl/alu_pipeline_elastic.sv
// DEPTH elastic transport slices followed by a registered half-word execute
// stage, with flush and a registered occupancy count.
module alu_pipeline_elastic
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_instr,
    input  logic [1:0]                    in_op,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W/2:0]             out_result,
    output logic [$clog2(DEPTH+2)-1:0]    occupancy
);

    localparam int DHALF_W = DATA_W / 2;
    localparam int DRES_W  = DHALF_W + 1;
    localparam int PW      = DATA_W + 2;
    localparam int OW      = $clog2(DEPTH + 2);

    // Index i is the input of slice i; index DEPTH feeds the execute stage.
    logic [DEPTH:0]         vld;
    logic [DEPTH:0]         rdy;
    logic [DEPTH:0][PW-1:0] dat;

    logic [DHALF_W-1:0]     ex_a;
    logic [DHALF_W-1:0]     ex_b;
    logic [1:0]             ex_op;
    logic [DRES_W-1:0]      exec_res;
    logic                   in_fire;
    logic                   out_fire;

    assign in_ready = !flush && !reset && rdy[0];
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign vld[0] = in_fire;
    assign dat[0] = {in_op, in_instr};
    assign rdy[DEPTH] = !out_valid || out_ready;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_slice
            pipe_slice #(.W(PW)) u_slice (
                .clk      (clk),
                .reset    (reset),
                .flush    (flush),
                .up_valid (vld[i]),
                .up_ready (rdy[i]),
                .up_data  (dat[i]),
                .dn_valid (vld[i+1]),
                .dn_ready (rdy[i+1]),
                .dn_data  (dat[i+1])
            );
        end
    endgenerate

    assign ex_a  = dat[DEPTH][DATA_W-1:DHALF_W];
    assign ex_b  = dat[DEPTH][DHALF_W-1:0];
    assign ex_op = dat[DEPTH][DATA_W+1:DATA_W];

    // The shared package function is sized for its own HALF_W; other widths use a local copy.
    generate
        if (DHALF_W == HALF_W) begin : g_pkg_exec
            assign exec_res = alu_exec(ex_a, ex_b, op_e'(ex_op));
        end else begin : g_local_exec
            // Same zero-extended arithmetic as alu_exec, at this instance's width.
            always_comb begin
                exec_res = '0;
                case (ex_op)
                    2'd0:    exec_res = {1'b0, ex_a} + {1'b0, ex_b};
                    2'd1:    exec_res = {1'b0, ex_a} - {1'b0, ex_b};
                    2'd2:    exec_res = {1'b0, ex_a & ex_b};
                    default: exec_res = {1'b0, ex_a ^ ex_b};
                endcase
            end
        end
    endgenerate

    // Execute on the edge that moves the last slice into the output register; flush freezes the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (rdy[DEPTH])
                out_valid <= vld[DEPTH];
            if (vld[DEPTH] && rdy[DEPTH] && !flush)
                out_result <= exec_res;
        end
    end

    // Items only enter and leave at the ends, so the count moves by in_fire - out_fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            occupancy <= '0;
        else if (flush)
            occupancy <= '0;
        else
            occupancy <= occupancy + OW'(in_fire) - OW'(out_fire);
    end

endmodule

// File: tb/tb_alu_pipeline_elastic.sv
// Randomized bench for alu_pipeline_elastic with a queue-based reference model.
module tb_alu_pipeline_elastic;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [1:0]  in_op = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [16:0] out_result;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;
    int q[$];
    bit fo;
    bit acc;
    int got;
    int exp_r;

    alu_pipeline_elastic #(.DATA_W(32), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_op      (in_op),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    function automatic int ref_exec(input logic [31:0] ins, input logic [1:0] op);
        int a;
        int b;
        int r;
        a = {16'd0, ins[31:16]};
        b = {16'd0, ins[15:0]};
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            default: r = a ^ b;
        endcase
        return r & 32'h1FFFF;
    endfunction

    // One clock: observe handshakes, update the model, advance to just after the edge.
    task automatic cyc();
        #1;
        fo    = out_valid && out_ready;
        acc   = in_valid && in_ready;
        got   = int'(out_result);
        exp_r = -1;
        if (fo && q.size() > 0) exp_r = q.pop_front();
        if (acc) q.push_back(ref_exec(in_instr, in_op));
        if (flush) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++; if (out_result !== 17'h0) begin errors++; $display("FAIL reset_out_result: got %0h want 0", out_result); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0003_0005;
        in_op     = 2'd0;
        cyc();
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL lat_accept: got %0b want 1", acc); end
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got out_valid %0b want 0 after 2 edges", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_result !== 17'h0_0008) begin
            errors++; $display("FAIL lat_add: got valid %0b result %0h want 1 / 8", out_valid, out_result);
        end
        cyc();
        checks++; if (!fo || got !== exp_r) begin errors++; $display("FAIL lat_model: got %0h want %0h", got, exp_r); end
    endtask

    task automatic test_corners();
        logic [31:0] ins [4];
        logic [1:0]  ops [4];
        int          want [4];
        bit          done;
        ins[0] = 32'hFFFF_0001; ops[0] = 2'd0; want[0] = 'h1_0000;
        ins[1] = 32'h0001_0002; ops[1] = 2'd1; want[1] = 'h1_FFFF;
        ins[2] = 32'hF0F0_FF00; ops[2] = 2'd2; want[2] = 'h0_F000;
        ins[3] = 32'hF0F0_FF00; ops[3] = 2'd3; want[3] = 'h0_0FF0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_instr = ins[k];
            in_op    = ops[k];
            in_valid = 1'b1;
            cyc();
            in_valid = 1'b0;
            done = 1'b0;
            for (int t = 0; t < 20 && !done; t++) begin
                cyc();
                if (fo) begin
                    done = 1'b1;
                    checks++; if (got !== want[k] || got !== exp_r) begin
                        errors++; $display("FAIL corner_%0d: got %0h want %0h", k, got, want[k]);
                    end
                end
            end
            if (!done) begin checks++; errors++; $display("FAIL corner_%0d_timeout: got no output want one", k); end
        end
    endtask

    task automatic test_back_to_back();
        int   n_sent;
        int   n_got;
        bit   stall;
        logic [16:0] held;
        n_sent = 0;
        n_got  = 0;
        in_instr = $urandom;
        in_op    = 2'($urandom_range(0, 3));
        for (int c = 0; c < 80 && n_got < 8; c++) begin
            in_valid  = (n_sent < 8);
            out_ready = (c >= 5);
            stall = out_valid && !out_ready;
            held  = out_result;
            cyc();
            if (acc) begin
                n_sent++;
                in_instr = $urandom;
                in_op    = 2'($urandom_range(0, 3));
            end
            if (fo) begin
                n_got++;
                checks++; if (got !== exp_r) begin errors++; $display("FAIL bp_result_%0d: got %0h want %0h", n_got, got, exp_r); end
            end
            if (stall) begin
                checks++; if (out_valid !== 1'b1 || out_result !== held) begin
                    errors++; $display("FAIL bp_stable: got %0b/%0h want 1/%0h", out_valid, out_result, held);
                end
            end
            checks++; if (int'(occupancy) !== q.size()) begin
                errors++; $display("FAIL bp_occupancy: got %0d want %0d", occupancy, q.size());
            end
            if (c == 4) begin
                checks++; if (occupancy !== 2'd3 || in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_full: got occ %0d in_ready %0b want 3 / 0", occupancy, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (n_got !== 8 || q.size() !== 0) begin
            errors++; $display("FAIL bp_count: got %0d delivered, %0d left want 8, 0", n_got, q.size());
        end
    endtask

    task automatic test_bubbles();
        int n_sent;
        n_sent = 0;
        out_ready = 1'b0;
        in_instr = $urandom;
        in_op    = 2'($urandom_range(0, 3));
        for (int c = 0; c < 40 && n_sent < 3; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            cyc();
            if (acc) begin
                n_sent++;
                in_instr = $urandom;
                in_op    = 2'($urandom_range(0, 3));
            end
        end
        in_valid = 1'b1;
        #1;
        checks++; if (occupancy !== 2'd3 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bubble_full: got occ %0d in_ready %0b want 3 / 0", occupancy, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && q.size() > 0; t++) begin
            cyc();
            if (fo) begin
                checks++; if (got !== exp_r) begin errors++; $display("FAIL bubble_result: got %0h want %0h", got, exp_r); end
            end
        end
        checks++; if (q.size() !== 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bubble_drain: got %0d left valid %0b want 0 / 0", q.size(), out_valid);
        end
    endtask

    task automatic test_flush();
        logic [16:0] held;
        logic [31:0] y;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instr = $urandom;
            in_op    = 2'($urandom_range(0, 3));
            cyc();
        end
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL flush_pre_occ: got %0d want 3", occupancy); end
        held     = out_result;
        in_instr = $urandom;
        flush    = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL flush_clear: got valid %0b occ %0d want 0 / 0", out_valid, occupancy);
        end
        checks++; if (out_result !== held) begin errors++; $display("FAIL flush_result_kept: got %0h want %0h", out_result, held); end
        y         = $urandom;
        in_instr  = y;
        in_op     = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_next_early: got %0b want 0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1 || int'(out_result) !== ref_exec(y, 2'd1)) begin
            errors++; $display("FAIL flush_next: got %0b/%0h want 1/%0h", out_valid, out_result, ref_exec(y, 2'd1));
        end
        cyc();
        checks++; if (!fo || got !== exp_r) begin errors++; $display("FAIL flush_next_model: got %0h want %0h", got, exp_r); end
    endtask

    task automatic test_reset_mid();
        bit done;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_instr = $urandom;
            in_op    = 2'($urandom_range(0, 3));
            cyc();
        end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_result !== 17'h0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midreset: got valid %0b occ %0d res %0h rdy %0b want all 0",
                               out_valid, occupancy, out_result, in_ready);
        end
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        in_instr = $urandom;
        in_op    = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
        cyc();
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL midreset_accept: got %0b want 1", acc); end
        in_valid = 1'b0;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            cyc();
            if (fo) begin
                done = 1'b1;
                checks++; if (got !== exp_r) begin errors++; $display("FAIL midreset_result: got %0h want %0h", got, exp_r); end
            end
        end
        if (!done) begin checks++; errors++; $display("FAIL midreset_timeout: got no output want one"); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners();
        test_back_to_back();
        test_bubbles();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

endmodule
